// File: rtl/shift_cmd_if.sv
// Command channel into shift_cmd_sequencer: valid/ready handshake plus op, count and data.
interface shift_cmd_if #(
    parameter int unsigned CNT_W = 3
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [3:0]       cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_count, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_count, cmd_data, output cmd_ready);
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Sequences hold/shift/load commands onto a 4-bit universal shift register and mirrors its contents.
// Optional macro SHIFT_CMD_ROTATE_EN: ops 01/10 rotate the mirrored register instead of filling from cmd_data.
module shift_cmd_sequencer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    shift_cmd_if.slave  cmd,
    output logic [1:0]  select,
    output logic        shift_right,
    output logic        shift_left,
    output logic [3:0]  parallel_in,
    output logic [3:0]  shadow_q,
    output logic        busy,
    output logic        done
);
    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_SHR   = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic [3:0]       r_data, w_data_nxt;

    logic [1:0]       r_select, w_sel_nxt;
    logic             r_shift_right, w_sr_nxt;
    logic             r_shift_left, w_sl_nxt;
    logic [3:0]       r_parallel_in, w_pin_nxt;
    logic [3:0]       r_shadow, w_shadow_nxt;
    logic             r_busy, r_done;

    logic             w_run;
    logic [1:0]       w_run_op;
    logic [3:0]       w_run_data;
    logic [1:0]       w_run_idx;

    assign cmd.cmd_ready = (r_state == ST_IDLE);
    assign select        = r_select;
    assign shift_right   = r_shift_right;
    assign shift_left    = r_shift_left;
    assign parallel_in   = r_parallel_in;
    assign shadow_q      = r_shadow;
    assign busy          = r_busy;
    assign done          = r_done;

    // Downstream register model, driven by the outputs currently on the wires
    always_comb begin
        case (r_select)
            OP_SHR:  w_shadow_nxt = {r_shift_right, r_shadow[3:1]};
            OP_SHL:  w_shadow_nxt = {r_shadow[2:0], r_shift_left};
            OP_LOAD: w_shadow_nxt = r_parallel_in;
            default: w_shadow_nxt = r_shadow;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, counter bookkeeping and the output values for the upcoming cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_run       = 1'b0;
        w_run_op    = r_op;
        w_run_data  = r_data;
        w_run_idx   = r_idx;
        w_sel_nxt   = OP_HOLD;
        w_sr_nxt    = 1'b0;
        w_sl_nxt    = 1'b0;
        w_pin_nxt   = 4'b0000;

        case (r_state)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    w_op_nxt   = cmd.cmd_op;
                    w_data_nxt = cmd.cmd_data;
                    w_idx_nxt  = 2'd1;
                    if (cmd.cmd_op != OP_LOAD && cmd.cmd_count == '0) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = (cmd.cmd_op == OP_LOAD) ? CNT_W'(1) : cmd.cmd_count;
                        w_run       = 1'b1;
                        w_run_op    = cmd.cmd_op;
                        w_run_data  = cmd.cmd_data;
                        w_run_idx   = 2'd0;
                    end
                end
            end
            ST_RUN: begin
                // Zero is treated like one so the counter can never wrap
                if (r_cnt == CNT_W'(1) || r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_idx_nxt = r_idx + 2'd1;
                    w_run     = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_run) begin
            w_sel_nxt = w_run_op;
            case (w_run_op)
`ifdef SHIFT_CMD_ROTATE_EN
                OP_SHR:  w_sr_nxt = w_shadow_nxt[0];
                OP_SHL:  w_sl_nxt = w_shadow_nxt[3];
`else
                OP_SHR:  w_sr_nxt = w_run_data[w_run_idx];
                OP_SHL:  w_sl_nxt = w_run_data[w_run_idx];
`endif
                OP_LOAD: w_pin_nxt = w_run_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_idx         <= 2'd0;
            r_op          <= OP_HOLD;
            r_data        <= 4'b0000;
            r_select      <= OP_HOLD;
            r_shift_right <= 1'b0;
            r_shift_left  <= 1'b0;
            r_parallel_in <= 4'b0000;
            r_shadow      <= 4'b0000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_op          <= w_op_nxt;
            r_data        <= w_data_nxt;
            r_select      <= w_sel_nxt;
            r_shift_right <= w_sr_nxt;
            r_shift_left  <= w_sl_nxt;
            r_parallel_in <= w_pin_nxt;
            r_shadow      <= w_shadow_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_done        <= (w_state_nxt == ST_DONE);
        end
    end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed self-checking bench for shift_cmd_sequencer (default build; rotate scenario under SHIFT_CMD_ROTATE_EN).
module tb_shift_cmd_sequencer;
    logic       clk;
    logic       reset;
    logic [1:0] select;
    logic       shift_right;
    logic       shift_left;
    logic [3:0] parallel_in;
    logic [3:0] shadow_q;
    logic       busy;
    logic       done;
    int         n_tests;
    int         n_fail;

    shift_cmd_if #(.CNT_W(3)) sif ();

    shift_cmd_sequencer #(.CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (sif.slave),
        .select      (select),
        .shift_right (shift_right),
        .shift_left  (shift_left),
        .parallel_in (parallel_in),
        .shadow_q    (shadow_q),
        .busy        (busy),
        .done        (done)
    );

    // {select, shift_right, shift_left, parallel_in, busy, done, cmd_ready}
    logic [10:0] obs;
    assign obs = {select, shift_right, shift_left, parallel_in, busy, done, sif.cmd_ready};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; returns at the negedge of the first cycle after acceptance
    task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
        sif.cmd_op    = op;
        sif.cmd_count = cnt;
        sif.cmd_data  = data;
        sif.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sif.cmd_valid = 1'b0;
        sif.cmd_op = 2'b00;
        sif.cmd_count = 3'd0;
        sif.cmd_data = 4'b0000;
        @(negedge clk);
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs, {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1});
        end
        n_tests++;
        if (shadow_q !== 4'b0000) begin n_fail++; $display("FAIL reset_shadow got=%b exp=0000", shadow_q); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL post_reset_idle got=%b", obs);
        end
    endtask

    task automatic test_load();
        send(2'b11, 3'd5, 4'b1010);
        n_tests++;
        if (obs !== {2'b11, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL load_run got=%b exp=%b", obs, {2'b11, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL load_done got=%b", obs);
        end
        n_tests++;
        if (shadow_q !== 4'b1010) begin n_fail++; $display("FAIL load_shadow got=%b exp=1010", shadow_q); end
        @(negedge clk);
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL load_idle got=%b", obs);
        end
    endtask

    task automatic test_shift_right();
        logic [3:0] data;
        logic [3:0] sh;
        data = 4'b0011;
        sh   = 4'b1010;
        send(2'b01, 3'd4, data);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs !== {2'b01, data[k], 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL shr_cycle%0d got=%b exp=%b", k, obs, {2'b01, data[k], 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0});
            end
            n_tests++;
            if (shadow_q !== sh) begin n_fail++; $display("FAIL shr_shadow%0d got=%b exp=%b", k, shadow_q, sh); end
            sh = {data[k], sh[3:1]};
            @(negedge clk);
        end
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL shr_done got=%b", obs);
        end
        n_tests++;
        if (shadow_q !== 4'b0011) begin n_fail++; $display("FAIL shr_final_shadow got=%b exp=0011", shadow_q); end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        send(2'b10, 3'd0, 4'b1111);
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL zero_done got=%b", obs);
        end
        n_tests++;
        if (shadow_q !== 4'b0011) begin n_fail++; $display("FAIL zero_shadow got=%b exp=0011", shadow_q); end
        @(negedge clk);
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL zero_idle got=%b", obs);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cycles;
        busy_cycles = 0;
        sif.cmd_op    = 2'b00;
        sif.cmd_count = 3'd7;
        sif.cmd_data  = 4'b0000;
        sif.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.cmd_op    = 2'b11;
        sif.cmd_count = 3'd3;
        sif.cmd_data  = 4'b0101;
        for (int k = 0; k < 7; k++) begin
            if (busy) busy_cycles++;
            n_tests++;
            if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL hold_cycle%0d got=%b", k, obs);
            end
            @(negedge clk);
        end
        if (busy) busy_cycles++;
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL hold_done got=%b", obs);
        end
        @(negedge clk);
        if (busy) busy_cycles++;
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL b2b_idle got=%b", obs);
        end
        n_tests++;
        if (busy_cycles !== 8) begin n_fail++; $display("FAIL hold_busy_cycles got=%0d exp=8", busy_cycles); end
        @(negedge clk);
        sif.cmd_valid = 1'b0;
        n_tests++;
        if (obs !== {2'b11, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL b2b_second_cmd got=%b", obs);
        end
        @(negedge clk);
        n_tests++;
        if (shadow_q !== 4'b0101 || done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done got shadow=%b done=%b exp shadow=0101 done=1", shadow_q, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        send(2'b01, 3'd5, 4'b0110);
        repeat (2) @(negedge clk);
        n_tests++;
        if (select !== 2'b01 || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_running got select=%b busy=%b exp 01/1", select, busy);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL abort_immediate got=%b", obs);
        end
        n_tests++;
        if (shadow_q !== 4'b0000) begin n_fail++; $display("FAIL abort_shadow got=%b exp=0000", shadow_q); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL abort_ready got=%b", obs);
        end
        for (int k = 0; k < 8; k++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        n_tests++;
        if (done_seen !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d pulses exp=0", done_seen); end
    endtask

`ifdef SHIFT_CMD_ROTATE_EN
    task automatic test_rotate();
        logic [3:0] sh;
        send(2'b11, 3'd0, 4'b1000);
        repeat (2) @(negedge clk);
        sh = 4'b1000;
        send(2'b01, 3'd4, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (shadow_q !== sh || shift_right !== sh[0] || select !== 2'b01) begin
                n_fail++; $display("FAIL rot_cycle%0d got shadow=%b sr=%b sel=%b exp shadow=%b sr=%b sel=01", k, shadow_q, shift_right, select, sh, sh[0]);
            end
            sh = {sh[0], sh[3:1]};
            @(negedge clk);
        end
        n_tests++;
        if (shadow_q !== 4'b1000 || done !== 1'b1) begin
            n_fail++; $display("FAIL rot_final got shadow=%b done=%b exp shadow=1000 done=1", shadow_q, done);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_load();
`ifdef SHIFT_CMD_ROTATE_EN
        test_rotate();
`else
        test_shift_right();
        test_zero_count();
`endif
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
